// File: rtl/cmos_xor_lane_array_ctrl.sv
// Sequencer for complementary-rail CMOS XOR lanes: key reg, rail drive, settle, capture.
// Optional XOR_CHECK_EN adds a digital reference check and the err_count port.
module cmos_xor_lane_array_ctrl #(
  parameter int BIT_SIZE      = 64,
  parameter int LANES         = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int ROT_STEP      = 1,
  localparam int W            = LANES * BIT_SIZE
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [W-1:0] key_in,
  input  logic         key_load,
  input  logic         key_rotate_en,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [W-1:0] x_top,
  output logic [W-1:0] x_bar_top,
  output logic [W-1:0] k_top,
  output logic [W-1:0] k_bar_top,
  input  logic [W-1:0] s_top
`ifdef XOR_CHECK_EN
  ,
  output logic [15:0]  err_count
`endif
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RS = ROT_STEP % BIT_SIZE;

  typedef enum logic [1:0] {
    IDLE, SETTLE, CAPTURE, OUT
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [W-1:0]  key;
  logic          accept;
  logic          done;

  // per-lane left rotate; lanes never exchange bits
  function automatic logic [W-1:0] rot_key(input logic [W-1:0] k);
    logic [W-1:0]          r;
    logic [2*BIT_SIZE-1:0] d;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      d = {k[i*BIT_SIZE +: BIT_SIZE], k[i*BIT_SIZE +: BIT_SIZE]} << RS;
      r[i*BIT_SIZE +: BIT_SIZE] = d[2*BIT_SIZE-1 -: BIT_SIZE];
    end
    return r;
  endfunction

  assign in_ready  = (state == IDLE) && !key_load;
  assign busy      = (state != IDLE);
  assign k_top     = key;
  assign k_bar_top = ~key;
  assign x_bar_top = ~x_top;

  // state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_n;
  end

  // next-state and handshake strobes
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        accept = in_valid && in_ready;
        if (accept) state_n = SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) state_n = CAPTURE;
      end
      CAPTURE: state_n = OUT;
      OUT: begin
        done = out_ready;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // key, rails, settle counter and output register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      key       <= '0;
      x_top     <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == IDLE && key_load)
        key <= key_in;
      else if (done && key_rotate_en)
        key <= rot_key(key);
      if (accept) begin
        x_top <= in_data;
        cnt   <= CW'(SETTLE_CYCLES - 1);
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == CAPTURE) begin
        out_data  <= s_top;
        out_valid <= 1'b1;
      end else if (done) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef XOR_CHECK_EN
  // saturating count of lane results that disagree with x^k
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      err_count <= '0;
    else if (state == CAPTURE && s_top != (x_top ^ k_top) && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cmos_xor_lane_array_ctrl.sv
// Randomized bench for cmos_xor_lane_array_ctrl with a transaction-level model.
// Directed cases pin the model; XOR_CHECK_EN adds an error-counter scenario.
module tb_cmos_xor_lane_array_ctrl;
  localparam int BS = 64;
  localparam int LN = 2;
  localparam int ST = 3;
  localparam int W  = BS * LN;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         rot_en = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic [W-1:0] x_top, x_bar_top, k_top, k_bar_top;
  logic [W-1:0] s_top = '0;
  logic [W-1:0] fault_mask = '0;
`ifdef XOR_CHECK_EN
  logic [15:0]  err_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cmos_xor_lane_array_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .key_in(key_in), .key_load(key_load), .key_rotate_en(rot_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy),
    .x_top(x_top), .x_bar_top(x_bar_top),
    .k_top(k_top), .k_bar_top(k_bar_top),
    .s_top(s_top)
`ifdef XOR_CHECK_EN
    , .err_count(err_count)
`endif
  );

  // lane macro: s = x ^ k, one cycle late, optional stuck-at-0 bits
  always @(posedge clk) s_top <= (x_top ^ k_top) & ~fault_mask;

  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  // ---- transaction-level reference model ----
  logic [W-1:0] m_key, m_x, m_out;
  logic         m_ov;
  int           m_age;
  logic [15:0]  m_err;

  function automatic logic [W-1:0] m_rot(input logic [W-1:0] k);
    logic [W-1:0] r;
    for (int l = 0; l < LN; l++)
      for (int j = 0; j < BS; j++)
        r[l*BS + ((j + 1) % BS)] = k[l*BS + j];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_key <= '0; m_x <= '0; m_out <= '0;
      m_ov <= 1'b0; m_age <= -1; m_err <= '0;
    end else if (m_age < 0) begin
      if (key_load) m_key <= key_in;
      else if (in_valid) begin m_x <= in_data; m_age <= 0; end
    end else if (!m_ov) begin
      m_age <= m_age + 1;
      if (m_age + 1 == ST + 1) begin
        m_out <= (m_x ^ m_key) & ~fault_mask;
        m_ov  <= 1'b1;
        if (((m_x ^ m_key) & fault_mask) != '0 && m_err != 16'hFFFF)
          m_err <= m_err + 16'd1;
      end
    end else if (out_ready) begin
      m_ov  <= 1'b0;
      m_age <= -1;
      if (rot_en) m_key <= m_rot(m_key);
    end
  end

  // compare every cycle out of reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", W'(in_ready), W'((m_age < 0) && !key_load));
      chk("busy", W'(busy), W'(m_age >= 0));
      chk("out_valid", W'(out_valid), W'(m_ov));
      chk("out_data", out_data, m_out);
      chk("x_top", x_top, m_x);
      chk("x_bar_top", x_bar_top, ~m_x);
      chk("k_top", k_top, m_key);
      chk("k_bar_top", k_bar_top, ~m_key);
`ifdef XOR_CHECK_EN
      chk("err_count", W'(err_count), W'(m_err));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk("out_timeout", W'(out_valid), W'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin tick(); n++; end
    chk("idle_timeout", W'(busy), W'(0));
  endtask

  task automatic send(input logic [W-1:0] d);
    in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  localparam logic [W-1:0] ONES = {W{1'b1}};

  initial begin
    int lat;
    logic [W-1:0] k2, d2, exp_rot;
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_x_bar", x_bar_top, ONES);
    chk("rst_k_bar", k_bar_top, ONES);
    rst = 1'b0;
    tick();

    // basic
    key_in = {16{8'h0F}}; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    chk("basic_key", k_top, {16{8'h0F}});
    send(ONES);
    chk("basic_busy", W'(busy), W'(1));
    wait_out(lat);
    chk("basic_latency", W'(lat), W'(ST + 1));
    chk("basic_data", out_data, {16{8'hF0}});

    // backpressure
    in_data = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_data", out_data, {16{8'hF0}});
      chk("bp_in_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", W'(in_ready), W'(1));
    tick();
    in_valid = 1'b0;
    chk("bp_accept", W'(busy), W'(1));
    wait_idle();

    // key_load beats in_valid
    k2 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    key_in = k2; key_load = 1'b1; in_data = d2; in_valid = 1'b1;
    #1 chk("prio_ready", W'(in_ready), W'(0));
    tick();
    key_load = 1'b0;
    chk("prio_not_taken", W'(busy), W'(0));
    chk("prio_key", k_top, k2);
    tick();
    in_valid = 1'b0;
    chk("prio_taken", W'(busy), W'(1));
    wait_idle();
    chk("prio_result", out_data, d2 ^ k2);

    // keystream rotation
    key_in = {64'h1, 64'h1}; key_load = 1'b1;
    tick();
    key_load = 1'b0; rot_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send('0);
      wait_out(lat);
      exp_rot = (i == 0) ? {64'h1, 64'h1} : (i == 1) ? {64'h2, 64'h2} : {64'h4, 64'h4};
      chk("rot_data", out_data, exp_rot);
      tick();
    end
    rot_en = 1'b0;

    // async reset mid-settle
    send(ONES);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_out_valid", W'(out_valid), W'(0));
    chk("mid_rst_x_bar", x_bar_top, ONES);
    chk("mid_rst_k_bar", k_bar_top, ONES);
    tick();
    rst = 1'b0;
    tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      key_load  = ($urandom_range(0, 7) == 0);
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = $urandom_range(0, 2) != 0;
      rot_en    = $urandom_range(0, 1) == 1;
      tick();
    end
    key_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rot_en = 1'b0;
    wait_idle();

`ifdef XOR_CHECK_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fault_mask = W'(1) << 5;
    key_in = '0; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      send(W'(32'h20));
      wait_idle();
      chk("err_count_step", W'(err_count), W'(i));
    end
    fault_mask = '0;
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
